// File: rtl/blockmem_host_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// blockmem_host_loader
//
// Host-side sequencer between the host/DMA interface and the block memory.
//
// Write command: the host streams BLOCK_SIZE words, one per wr handshake. The
// words are assembled into a block buffer and committed as a single
// whole-block loader write. The commit is held off while the systolic array
// is writing C tiles, so a loader write never coincides with a C write.
//
// Read command: the whole block at the aligned address is snapshotted from the
// combinational thread0 read port in one cycle and then streamed back to the
// host word by word.
//
// Ports:
//   clock, reset           clock and synchronous active-high reset
//   cmd_valid/ready        command handshake (ready only when idle)
//   cmd_write              1 = block write, 0 = block read
//   cmd_addr               word address; offset bits within a block ignored
//   wr_valid/ready/data    host write-word stream (ready only while filling)
//   rd_valid/ready/data    host read-word stream (valid only while draining)
//   array_busy             array is writing C tiles; blocks the commit
//   loader_write_*         whole-block write port of the block memory
//   thread0_read_addr/data whole-block read port of the block memory
//   done                   one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module blockmem_host_loader #(
    parameter int BITWIDTH  = 16,
    parameter int MESHUNITS = 2,
    parameter int TILEUNITS = 2,
    parameter int ADDRSIZE  = 256
) (
    input  logic                clock,
    input  logic                reset,
    // host command
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [BITWIDTH-1:0] cmd_addr,
    // host write stream
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [BITWIDTH-1:0] wr_data,
    // host read stream
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [BITWIDTH-1:0] rd_data,
    // array activity
    input  logic                array_busy,
    // block memory loader write port
    output logic [BITWIDTH-1:0] loader_write_addr,
    output logic                loader_write_valid,
    output logic [BITWIDTH-1:0] loader_write_data [MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS],
    // block memory thread0 read port
    output logic [BITWIDTH-1:0] thread0_read_addr,
    input  logic [BITWIDTH-1:0] thread0_read_data [MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS],
    // completion
    output logic                done
);

    localparam int BLOCK_SIZE = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;
    localparam int CNT_W      = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ZERO   = CNT_W'(0);
    // Clearing the in-block offset bits and masking to the memory depth gives
    // the block-aligned, wrapped base address in one AND.
    localparam logic [BITWIDTH-1:0] ALIGN_MASK = ~BITWIDTH'(BLOCK_SIZE - 1);
    localparam logic [BITWIDTH-1:0] DEPTH_MASK = BITWIDTH'(ADDRSIZE - 1);
    localparam logic [BITWIDTH-1:0] BASE_MASK  = ALIGN_MASK & DEPTH_MASK;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        COMMIT = 3'd2,
        SNAP   = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [BITWIDTH-1:0] word_buf_r [BLOCK_SIZE];
    logic [CNT_W-1:0]    count_r;
    logic [BITWIDTH-1:0] base_r;
    logic                count_last_s;

    // Last word of the block is being transferred in FILL/DRAIN.
    always_comb begin
        count_last_s = (count_r == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_next_s       = state_r;
        cmd_ready          = 1'b0;
        wr_ready           = 1'b0;
        rd_valid           = 1'b0;
        loader_write_valid = 1'b0;
        done               = 1'b0;
        case (state_r)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next_s = cmd_write ? FILL : SNAP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                wr_ready = 1'b1;
                if (wr_valid && count_last_s) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = FILL;
                end
            end
            COMMIT: begin
                // Commit only in a cycle with no C write in flight; a reset
                // landing here discards the block without a strobe.
                if (!array_busy && !reset) begin
                    loader_write_valid = 1'b1;
                    done               = 1'b1;
                    state_next_s       = IDLE;
                end else begin
                    state_next_s = COMMIT;
                end
            end
            SNAP: begin
                state_next_s = DRAIN;
            end
            DRAIN: begin
                rd_valid = 1'b1;
                if (rd_ready && count_last_s) begin
                    done         = !reset;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Base address, word counter and block buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_r  <= '0;
            count_r <= CNT_ZERO;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                word_buf_r[i] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        base_r  <= cmd_addr & BASE_MASK;
                        count_r <= CNT_ZERO;
                    end
                end
                FILL: begin
                    if (wr_valid) begin
                        word_buf_r[count_r] <= wr_data;
                        count_r <= count_last_s ? CNT_ZERO : (count_r + CNT_ONE);
                    end
                end
                SNAP: begin
                    for (int i = 0; i < BLOCK_SIZE; i++) begin
                        word_buf_r[i] <= thread0_read_data[i];
                    end
                    count_r <= CNT_ZERO;
                end
                DRAIN: begin
                    if (rd_ready) begin
                        count_r <= count_last_s ? CNT_ZERO : (count_r + CNT_ONE);
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Read word: the buffer entry under the counter, zero outside DRAIN.
    // Both only change on a handshake, so the word holds while stalled.
    always_comb begin
        rd_data = '0;
        if (state_r == DRAIN) begin
            rd_data = word_buf_r[count_r];
        end else begin
            rd_data = '0;
        end
    end

    // Block memory addresses and write data follow the latched state directly.
    always_comb begin
        loader_write_addr = base_r;
        thread0_read_addr = base_r;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            loader_write_data[i] = word_buf_r[i];
        end
    end

endmodule

// File: tb/tb_blockmem_host_loader.sv
`timescale 1ns/1ps
module tb_blockmem_host_loader;

    localparam int BS = 16;
    localparam int AS = 256;

    localparam int M_IDLE   = 0;
    localparam int M_FILL   = 1;
    localparam int M_COMMIT = 2;
    localparam int M_SNAP   = 3;
    localparam int M_DRAIN  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'h0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = 16'h0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [15:0] rd_data;
    logic        array_busy = 1'b0;
    logic [15:0] loader_write_addr;
    logic        loader_write_valid;
    logic [15:0] loader_write_data [BS];
    logic [15:0] thread0_read_addr;
    logic [15:0] thread0_read_data [BS];
    logic        done;

    blockmem_host_loader #(
        .BITWIDTH (16),
        .MESHUNITS(2),
        .TILEUNITS(2),
        .ADDRSIZE (AS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_data           (rd_data),
        .array_busy        (array_busy),
        .loader_write_addr (loader_write_addr),
        .loader_write_valid(loader_write_valid),
        .loader_write_data (loader_write_data),
        .thread0_read_addr (thread0_read_addr),
        .thread0_read_data (thread0_read_data),
        .done              (done)
    );

    always #5 clock = ~clock;

    // ---------------- reference model state ----------------
    int          errors = 0;
    int          checks = 0;
    int          mode = M_IDLE;          // which phase of a command the host expects
    logic [15:0] exp_base = 16'h0;
    logic [15:0] mem [AS];               // contents of the modelled block memory
    logic [7:0]  rbase = 8'h0;
    bit          scramble = 1'b0;        // corrupt read port after the snapshot
    logic [15:0]  commit_addr_q [$];
    logic [255:0] commit_data_q [$];
    logic [15:0]  rd_q [$];
    int          n_strobes = 0;
    int          n_done = 0;
    int          n_cmds = 0;
    int          n_cap_rd = 0;
    logic [15:0] cap_addr = 16'h0;
    logic [15:0] cap_t0 = 16'h0;
    logic [15:0] cap_data [BS];
    logic [15:0] cap_rd [BS];

    // Memory read port as seen by the DUT.
    always_comb begin
        for (int i = 0; i < BS; i++) begin
            thread0_read_data[i] = scramble ? (mem[int'(rbase) + i] ^ 16'hA5A5)
                                            : mem[int'(rbase) + i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] align(input logic [15:0] a);
        return 16'(((int'(a) / BS) * BS) % AS);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Compare process: every cycle out of reset, outputs against the model.
    initial begin : compare
        bit          stalled;
        logic [15:0] held;
        bit          exp_lwv;
        bit          exp_done;
        logic [15:0]  ea;
        logic [255:0] ed;
        stalled = 1'b0;
        held = 16'h0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                exp_lwv  = (mode == M_COMMIT) && !array_busy;
                exp_done = exp_lwv || ((mode == M_DRAIN) && rd_ready && (rd_q.size() == 1));
                check("cmd_ready", 64'(cmd_ready), 64'(mode == M_IDLE));
                check("wr_ready", 64'(wr_ready), 64'(mode == M_FILL));
                check("rd_valid", 64'(rd_valid), 64'(mode == M_DRAIN));
                check("lw_addr", 64'(loader_write_addr), 64'(exp_base));
                check("t0_addr", 64'(thread0_read_addr), 64'(exp_base));
                check("lw_valid", 64'(loader_write_valid), 64'(exp_lwv));
                check("done", 64'(done), 64'(exp_done));
                if (mode == M_SNAP) cap_t0 = thread0_read_addr;
                if (loader_write_valid) begin
                    n_strobes++;
                    check("commit_pending", 64'(commit_addr_q.size() != 0), 64'd1);
                    if (commit_addr_q.size() != 0) begin
                        ea = commit_addr_q.pop_front();
                        ed = commit_data_q.pop_front();
                        check("lw_commit_addr", 64'(loader_write_addr), 64'(ea));
                        for (int i = 0; i < BS; i++) begin
                            check("lw_data", 64'(loader_write_data[i]), 64'(ed[i*16 +: 16]));
                        end
                    end
                    cap_addr = loader_write_addr;
                    for (int i = 0; i < BS; i++) cap_data[i] = loader_write_data[i];
                end
                if (rd_valid && stalled) check("rd_stable", 64'(rd_data), 64'(held));
                if (rd_valid && rd_ready) begin
                    check("rd_pending", 64'(rd_q.size() != 0), 64'd1);
                    if (rd_q.size() != 0) check("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
                    if (n_cap_rd < BS) cap_rd[n_cap_rd] = rd_data;
                    n_cap_rd++;
                end
                stalled = rd_valid && !rd_ready;
                held = rd_data;
                if (done) n_done++;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Block write: command, BLOCK_SIZE beats with random gaps, then commit
    // after busy_n cycles of array_busy.
    task automatic do_write(input logic [15:0] addr, input int busy_n,
                            input bit hold_cmd, input bit fixed_data);
        logic [15:0]  words [BS];
        logic [255:0] flat;
        logic [15:0]  base;
        int           i;
        base = align(addr);
        for (int k = 0; k < BS; k++) begin
            words[k] = fixed_data ? 16'(k + 1) : 16'($urandom);
            flat[k*16 +: 16] = words[k];
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        array_busy = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = addr;
        tick();
        mode = M_FILL;
        exp_base = base;
        if (!hold_cmd) cmd_valid = 1'b0;
        i = 0;
        while (i < BS) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
                wr_data = 16'($urandom);
            end else begin
                wr_valid = 1'b1;
                wr_data = words[i];
            end
            rd_ready = 1'($urandom);
            if (hold_cmd) begin
                cmd_addr = 16'($urandom);
                cmd_write = 1'($urandom);
            end
            tick();
            if (wr_valid) i++;
        end
        cmd_valid = 1'b0;
        rd_ready = 1'b0;
        commit_addr_q.push_back(base);
        commit_data_q.push_back(flat);
        mode = M_COMMIT;
        wr_valid = 1'($urandom);
        wr_data = 16'($urandom);
        array_busy = (busy_n > 0);
        for (int k = 0; k < busy_n; k++) begin
            @(negedge clock);
            check("commit_held", 64'({loader_write_valid, done}), 64'd0);
            tick();
        end
        array_busy = 1'b0;
        @(negedge clock);
        check("commit_strobe", 64'({loader_write_valid, done}), 64'd3);
        tick();
        mode = M_IDLE;
        wr_valid = 1'b0;
        for (int k = 0; k < BS; k++) mem[int'(base) + k] = words[k];
        n_cmds++;
    endtask

    // Write aborted by reset after nwords beats.
    task automatic do_aborted_write(input logic [15:0] addr, input int nwords);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = addr;
        tick();
        cmd_valid = 1'b0;
        mode = M_FILL;
        exp_base = align(addr);
        for (int k = 0; k < nwords; k++) begin
            wr_valid = 1'b1;
            wr_data = 16'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mode = M_IDLE;
        exp_base = 16'h0;
        @(negedge clock);
        for (int k = 0; k < BS; k++) check("buf_cleared", 64'(loader_write_data[k]), 64'd0);
        check("rd_data_idle", 64'(rd_data), 64'd0);
        tick();
    endtask

    // Block read: snapshot then drain with random or alternating rd_ready.
    task automatic do_read(input logic [15:0] addr, input bit toggle);
        logic [15:0] base;
        int beats;
        int guard;
        bit ph;
        base = align(addr);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        array_busy = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = addr;
        rbase = base[7:0];
        tick();
        cmd_valid = 1'b0;
        mode = M_SNAP;
        exp_base = base;
        for (int k = 0; k < BS; k++) rd_q.push_back(mem[int'(base) + k]);
        n_cap_rd = 0;
        wr_valid = 1'($urandom);
        tick();
        wr_valid = 1'b0;
        mode = M_DRAIN;
        scramble = 1'b1;
        beats = 0;
        guard = 0;
        ph = 1'b0;
        while (beats < BS && guard < 1000) begin
            if (toggle) begin
                rd_ready = ph;
                ph = !ph;
            end else begin
                rd_ready = 1'($urandom);
            end
            array_busy = 1'($urandom);
            tick();
            if (rd_ready) beats++;
            guard++;
        end
        check("drain_bound", 64'(guard < 1000), 64'd1);
        mode = M_IDLE;
        scramble = 1'b0;
        rd_ready = 1'b0;
        array_busy = 1'b0;
        n_cmds++;
        check("rd_all_popped", 64'(rd_q.size()), 64'd0);
    endtask

    initial begin : stimulus
        int s0;
        int d0;
        for (int k = 0; k < AS; k++) mem[k] = 16'($urandom);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < BS; k++) check("reset_lw_data", 64'(loader_write_data[k]), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        check("reset_lw_addr", 64'(loader_write_addr), 64'd0);
        tick();

        // Write words 1..16 to 0x23
        s0 = n_strobes;
        do_write(16'h0023, 0, 1'b0, 1'b1);
        check("t1_strobes", 64'(n_strobes - s0), 64'd1);
        check("t1_addr", 64'(cap_addr), 64'h20);
        for (int k = 0; k < BS; k++) check("t1_data", 64'(cap_data[k]), 64'(k + 1));

        // Commit deferred by 5 busy cycles
        s0 = n_strobes;
        do_write(16'h0040, 5, 1'b0, 1'b0);
        check("t2_strobes", 64'(n_strobes - s0), 64'd1);
        check("t2_addr", 64'(cap_addr), 64'h40);

        // Read 0x10 with known contents
        for (int k = 0; k < BS; k++) mem[16 + k] = 16'(16'h0100 + k);
        do_read(16'h0010, 1'b0);
        check("t3_t0addr", 64'(cap_t0), 64'h10);
        check("t3_beats", 64'(n_cap_rd), 64'd16);
        for (int k = 0; k < BS; k++) check("t3_rd", 64'(cap_rd[k]), 64'(16'h0100 + k));

        // Read with rd_ready alternating
        do_read(16'h0047, 1'b1);
        check("t4_beats", 64'(n_cap_rd), 64'd16);

        // Reset after 7 words, then a full write and read-back
        s0 = n_strobes;
        d0 = n_done;
        do_aborted_write(16'h0080, 7);
        check("t5_no_strobe", 64'(n_strobes - s0), 64'd0);
        check("t5_no_done", 64'(n_done - d0), 64'd0);
        do_write(16'h0080, 1, 1'b0, 1'b0);
        check("t5_strobes", 64'(n_strobes - s0), 64'd1);
        do_read(16'h0085, 1'b0);

        // Held cmd_valid during FILL, address wrap
        s0 = n_strobes;
        do_write(16'h01F3, 2, 1'b1, 1'b0);
        check("t6_addr", 64'(cap_addr), 64'hF0);
        check("t6_strobes", 64'(n_strobes - s0), 64'd1);

        // Randomized command mix
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) begin
                wr_valid = 1'($urandom);
                rd_ready = 1'($urandom);
                array_busy = 1'($urandom);
                tick();
            end
            wr_valid = 1'b0;
            rd_ready = 1'b0;
            array_busy = 1'b0;
            if ($urandom_range(0, 1) == 1)
                do_write(16'($urandom), int'($urandom_range(0, 4)), 1'($urandom), 1'b0);
            else
                do_read(16'($urandom), 1'($urandom));
        end

        tick();
        check("done_count", 64'(n_done), 64'(n_cmds));
        check("commits_drained", 64'(commit_addr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
